// File: rtl/stopwatch_bcd_core.sv
// ---------------------------------------------------------------------------
// stopwatch_bcd_core
//   Stopwatch time-keeping core. Counts rollover pulses from the upstream
//   10 ms timer into a BCD MM:SS.CC value. It also provides run/pause/lap
//   control and a lap-freeze display latch.
//
//   Ports
//     clk          system clock
//     rst_n        asynchronous active-low reset
//     tick         one-cycle pulse from the 10 ms timer
//     start_stop   one-cycle pulse, run/pause toggle
//     lap          one-cycle pulse, freeze/unfreeze display
//     clear        one-cycle pulse, zero count (IDLE/PAUSE only)
//     disp_digits  {m10,m1,s10,s1,c10,c1}, 4-bit BCD each
//     running      high in RUN or LAP
//     frozen       high in LAP
//     overflow     sticky, set when the count wraps past MIN_LIMIT:59.99
//
//   state | meaning
//   IDLE  | stopped at zero, waiting for start
//   RUN   | counting, display live
//   LAP   | counting, display shows the lap latch
//   PAUSE | stopped, count held, clear allowed
// ---------------------------------------------------------------------------
module stopwatch_bcd_core #(
   parameter int TICK_DIV  = 1,
   parameter int MIN_LIMIT = 59
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        tick,
   input  logic        start_stop,
   input  logic        lap,
   input  logic        clear,
   output logic [23:0] disp_digits,
   output logic        running,
   output logic        frozen,
   output logic        overflow
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      LAP   = 2'd2,
      PAUSE = 2'd3
   } state_t;

   localparam logic [7:0] DIV_MAX = 8'(TICK_DIV - 1);
   localparam logic [3:0] MIN10   = 4'(MIN_LIMIT / 10);
   localparam logic [3:0] MIN1    = 4'(MIN_LIMIT % 10);

   state_t      state_q, state_d;
   logic [3:0]  m10_q, m1_q, s10_q, s1_q, c10_q, c1_q;
   logic [3:0]  m10_d, m1_d, s10_d, s1_d, c10_d, c1_d;
   logic [7:0]  div_q, div_d;
   logic [23:0] lap_q, lap_d;
   logic [23:0] disp_q, disp_d;
   logic        ovf_q, ovf_d;
   logic        run_q, run_d;
   logic        frz_q, frz_d;

   logic        count_en;
   logic        clear_cnt;
   logic [23:0] cnt_now;
   logic [23:0] cnt_next;

   assign cnt_now  = {m10_q, m1_q, s10_q, s1_q, c10_q, c1_q};
   assign cnt_next = {m10_d, m1_d, s10_d, s1_d, c10_d, c1_d};

   // Counting is qualified by the registered state, so a start pulse does
   // not count its own coincident tick, while a stop pulse does.
   assign count_en = tick && ((state_q == RUN) || (state_q == LAP));

   always_comb begin
      state_d   = state_q;
      lap_d     = lap_q;
      clear_cnt = 1'b0;
      unique case (state_q)
         IDLE: begin
            // clear outranks start_stop; it has no effect here beyond that
            if (!clear && start_stop) state_d = RUN;
         end
         RUN: begin
            if (start_stop) begin
               state_d = PAUSE;
            end else if (lap) begin
               state_d = LAP;
               lap_d   = cnt_now;
            end
         end
         LAP: begin
            if (start_stop)  state_d = PAUSE;
            else if (lap)    state_d = RUN;
         end
         PAUSE: begin
            if (clear) begin
               state_d   = IDLE;
               clear_cnt = 1'b1;
            end else if (start_stop) begin
               state_d = RUN;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      m10_d = m10_q;
      m1_d  = m1_q;
      s10_d = s10_q;
      s1_d  = s1_q;
      c10_d = c10_q;
      c1_d  = c1_q;
      div_d = div_q;
      ovf_d = ovf_q;
      if (count_en) begin
         if (div_q == DIV_MAX) begin
            div_d = 8'd0;
            if (c1_q != 4'd9) begin
               c1_d = c1_q + 4'd1;
            end else begin
               c1_d = 4'd0;
               if (c10_q != 4'd9) begin
                  c10_d = c10_q + 4'd1;
               end else begin
                  c10_d = 4'd0;
                  if (s1_q != 4'd9) begin
                     s1_d = s1_q + 4'd1;
                  end else begin
                     s1_d = 4'd0;
                     if (s10_q != 4'd5) begin
                        s10_d = s10_q + 4'd1;
                     end else begin
                        s10_d = 4'd0;
                        if ((m10_q == MIN10) && (m1_q == MIN1)) begin
                           m10_d = 4'd0;
                           m1_d  = 4'd0;
                           ovf_d = 1'b1;
                        end else if (m1_q != 4'd9) begin
                           m1_d = m1_q + 4'd1;
                        end else begin
                           m1_d  = 4'd0;
                           m10_d = m10_q + 4'd1;
                        end
                     end
                  end
               end
            end
         end else begin
            div_d = div_q + 8'd1;
         end
      end
      if (clear_cnt) begin
         m10_d = 4'd0;
         m1_d  = 4'd0;
         s10_d = 4'd0;
         s1_d  = 4'd0;
         c10_d = 4'd0;
         c1_d  = 4'd0;
         div_d = 8'd0;
         ovf_d = 1'b0;
      end
   end

   // Outputs are registered copies of next-state values so they move on
   // the same edge as the count they describe.
   always_comb begin
      disp_d = (state_d == LAP) ? lap_d : cnt_next;
      run_d  = (state_d == RUN) || (state_d == LAP);
      frz_d  = (state_d == LAP);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         m10_q   <= 4'd0;
         m1_q    <= 4'd0;
         s10_q   <= 4'd0;
         s1_q    <= 4'd0;
         c10_q   <= 4'd0;
         c1_q    <= 4'd0;
         div_q   <= 8'd0;
         lap_q   <= 24'd0;
         disp_q  <= 24'd0;
         ovf_q   <= 1'b0;
         run_q   <= 1'b0;
         frz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         m10_q   <= m10_d;
         m1_q    <= m1_d;
         s10_q   <= s10_d;
         s1_q    <= s1_d;
         c10_q   <= c10_d;
         c1_q    <= c1_d;
         div_q   <= div_d;
         lap_q   <= lap_d;
         disp_q  <= disp_d;
         ovf_q   <= ovf_d;
         run_q   <= run_d;
         frz_q   <= frz_d;
      end
   end

   assign disp_digits = disp_q;
   assign running     = run_q;
   assign frozen      = frz_q;
   assign overflow    = ovf_q;

endmodule

// File: tb/tb_stopwatch_bcd_core.sv
// ---------------------------------------------------------------------------
// tb_stopwatch_bcd_core
//   Directed bench for stopwatch_bcd_core. The main instance uses
//   MIN_LIMIT=1, so the wrap at 01:59.99 is reachable in a short run. A
//   second instance uses TICK_DIV=4 to cover the divider.
// ---------------------------------------------------------------------------
module tb_stopwatch_bcd_core;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        tick = 1'b0;
   logic        start_stop = 1'b0;
   logic        lap = 1'b0;
   logic        clear = 1'b0;

   logic [23:0] disp_digits;
   logic        running, frozen, overflow;
   logic [23:0] disp4;
   logic        running4, frozen4, overflow4;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   stopwatch_bcd_core #(.TICK_DIV(1), .MIN_LIMIT(1)) dut (
      .clk(clk), .rst_n(rst_n), .tick(tick), .start_stop(start_stop),
      .lap(lap), .clear(clear), .disp_digits(disp_digits),
      .running(running), .frozen(frozen), .overflow(overflow)
   );

   stopwatch_bcd_core #(.TICK_DIV(4), .MIN_LIMIT(59)) dut4 (
      .clk(clk), .rst_n(rst_n), .tick(tick), .start_stop(start_stop),
      .lap(lap), .clear(clear), .disp_digits(disp4),
      .running(running4), .frozen(frozen4), .overflow(overflow4)
   );

   task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // one clock of stimulus, outputs sampled 1 ns after the edge
   task automatic step(input logic ss, input logic lp, input logic cl, input logic tk);
      @(negedge clk);
      start_stop = ss;
      lap        = lp;
      clear      = cl;
      tick       = tk;
      @(posedge clk);
      #1;
      start_stop = 1'b0;
      lap        = 1'b0;
      clear      = 1'b0;
      tick       = 1'b0;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   initial begin
      // reset
      repeat (2) @(posedge clk);
      #1;
      chk("rst_disp", disp_digits, 24'h000000);
      chk("rst_running", {23'd0, running}, 24'd1 - 24'd1);
      chk("rst_frozen", {23'd0, frozen}, 24'd0);
      chk("rst_overflow", {23'd0, overflow}, 24'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // 1: start, 250 ticks, one-clock latency
      step(1'b1, 1'b0, 1'b0, 1'b0);
      chk("start_running", {23'd0, running}, 24'd1);
      ticks(249);
      chk("t249", disp_digits, 24'h000249);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      chk("t250_latency", disp_digits, 24'h000250);
      chk("t250_running", {23'd0, running}, 24'd1);

      // 2: second/minute carry, then wrap at 01:59.99
      ticks(5749);
      chk("t5999", disp_digits, 24'h005999);
      ticks(1);
      chk("min_carry", disp_digits, 24'h010000);
      ticks(5999);
      chk("at_limit", disp_digits, 24'h015999);
      chk("no_ovf_yet", {23'd0, overflow}, 24'd0);
      ticks(1);
      chk("wrap_disp", disp_digits, 24'h000000);
      chk("wrap_ovf", {23'd0, overflow}, 24'd1);
      chk("wrap_running", {23'd0, running}, 24'd1);

      // 3: lap freeze
      ticks(123);
      chk("pre_lap", disp_digits, 24'h000123);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      chk("lap_frozen", {23'd0, frozen}, 24'd1);
      chk("lap_disp", disp_digits, 24'h000123);
      ticks(100);
      chk("lap_hold", disp_digits, 24'h000123);
      chk("lap_running", {23'd0, running}, 24'd1);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      chk("unlap_disp", disp_digits, 24'h000223);
      chk("unlap_frozen", {23'd0, frozen}, 24'd0);

      // 4: clear ignored in RUN, pause holds, clear in PAUSE
      step(1'b0, 1'b0, 1'b1, 1'b0);
      chk("run_clear_ign", disp_digits, 24'h000223);
      chk("run_clear_running", {23'd0, running}, 24'd1);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      chk("pause_running", {23'd0, running}, 24'd0);
      ticks(5);
      chk("pause_hold", disp_digits, 24'h000223);
      chk("pause_ovf_sticky", {23'd0, overflow}, 24'd1);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      chk("clear_disp", disp_digits, 24'h000000);
      chk("clear_ovf", {23'd0, overflow}, 24'd0);

      // 5: coincident start_stop + tick
      step(1'b1, 1'b0, 1'b0, 1'b1);
      chk("idle_ss_tick_disp", disp_digits, 24'h000000);
      chk("idle_ss_tick_run", {23'd0, running}, 24'd1);
      step(1'b1, 1'b0, 1'b0, 1'b1);
      chk("run_ss_tick_disp", disp_digits, 24'h000001);
      chk("run_ss_tick_run", {23'd0, running}, 24'd0);
      step(1'b1, 1'b0, 1'b1, 1'b0);
      chk("pause_clr_ss_disp", disp_digits, 24'h000000);
      chk("pause_clr_ss_run", {23'd0, running}, 24'd0);

      // 6: divider of 4, then asynchronous reset mid-count
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      step(1'b1, 1'b0, 1'b0, 1'b0);
      ticks(3);
      chk("div4_t3", disp4, 24'h000000);
      ticks(5);
      chk("div4_t8", disp4, 24'h000002);
      ticks(4);
      chk("div4_t12", disp4, 24'h000003);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_disp", disp4, 24'h000000);
      chk("async_rst_running", {23'd0, running4}, 24'd0);
      chk("async_rst_main", disp_digits, 24'h000000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
